// File: rtl/dds_iq_model.sv
// dds_iq_model: phase-accumulator DDS with quarter-wave sine ROM, 3-stage pipeline to a {Q,I} stream
module dds_iq_model #(
   parameter int PHASE_W = 24,
   parameter int TRUNC_W = 12,
   parameter int AMP     = 32767
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PHASE_W-1:0] phase_axis_tdata_i,
   input  logic               phase_axis_tvalid_i,
   output logic [31:0]        iq_axis_tdata_o,
   output logic               iq_axis_tvalid_o
);
   localparam int  A_W = TRUNC_W - 2;
   localparam int  N   = 1 << A_W;
   localparam real PI  = 3.14159265358979323846;
   logic [14:0]        rom [N];
   logic [PHASE_W-1:0] inc_q, inc_d, acc_q, acc_d;
   logic [1:0]         quad1_q, quad2_q, fill_q, fill_d;
   logic [A_W-1:0]     idx_q;
   logic [14:0]        s_q, c_q;
   logic [31:0]        dat_q, dat_d;
   logic [15:0]        sp, cp, qv, iv;
   // Half-step offset keeps the table symmetric so L[N-1-k] is the exact cosine partner of L[k].
   for (genvar k = 0; k < N; k++) begin : g_rom
      localparam int V = $rtoi(real'(AMP) * $sin(2.0 * PI * (real'(k) + 0.5) / real'(4 * N)) + 0.5);
      assign rom[k] = V[14:0];
   end
   always_comb begin
      inc_d  = phase_axis_tvalid_i ? phase_axis_tdata_i : inc_q;
      acc_d  = acc_q + inc_q;
      fill_d = fill_q + {1'b0, ~&fill_q};
      sp     = {1'b0, s_q};
      cp     = {1'b0, c_q};
      qv     = quad2_q[0] ? (quad2_q[1] ? -cp : cp) : (quad2_q[1] ? -sp : sp);
      iv     = quad2_q[0] ? (quad2_q[1] ? sp : -sp) : (quad2_q[1] ? -cp : cp);
      // Gate on fill so stale pipeline contents never reach the output after reset.
      dat_d  = fill_q[1] ? {qv, iv} : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         inc_q   <= '0;
         acc_q   <= '0;
         quad1_q <= '0;
         idx_q   <= '0;
         quad2_q <= '0;
         s_q     <= '0;
         c_q     <= '0;
         dat_q   <= '0;
         fill_q  <= '0;
      end else begin
         inc_q   <= inc_d;
         acc_q   <= acc_d;
         quad1_q <= acc_q[PHASE_W-1 -: 2];
         idx_q   <= acc_q[PHASE_W-3 -: A_W];
         quad2_q <= quad1_q;
         s_q     <= rom[idx_q];
         c_q     <= rom[~idx_q];
         dat_q   <= dat_d;
         fill_q  <= fill_d;
      end
   end
   assign iq_axis_tdata_o  = dat_q;
   assign iq_axis_tvalid_o = &fill_q;
endmodule

// File: tb/tb_dds_iq_model.sv
// tb_dds_iq_model: vector table plus per-cycle scoreboard against a reference DDS model
module tb_dds_iq_model;
   localparam real PI = 3.14159265358979323846;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] din = '0;
   logic        vld = 1'b0;
   logic [31:0] dout;
   logic        vout;
   int          n_vec = 0;
   int          n_bad = 0;
   logic [23:0] m_inc, m_acc;
   int          m_fill;
   logic [31:0] sb [$];
   typedef struct {
      logic        r;
      logic        v;
      logic [23:0] d;
      logic        chk;
      logic        ev;
      logic [31:0] ed;
   } vec_t;
   vec_t tbl [21];
   dds_iq_model dut (
      .clk(clk), .rst(rst),
      .phase_axis_tdata_i(din), .phase_axis_tvalid_i(vld),
      .iq_axis_tdata_o(dout), .iq_axis_tvalid_o(vout)
   );
   always #5 clk = ~clk;
   function automatic int lval(input int k);
      return $rtoi(32767.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 4096.0) + 0.5);
   endfunction
   function automatic logic [31:0] exp_iq(input logic [23:0] a);
      int s, c, q, i;
      s = lval(int'(a[21:12]));
      c = lval(1023 - int'(a[21:12]));
      case (a[23:22])
         2'd0: begin q = s;  i = c;  end
         2'd1: begin q = c;  i = -s; end
         2'd2: begin q = -s; i = -c; end
         default: begin q = -c; i = s; end
      endcase
      return {q[15:0], i[15:0]};
   endfunction
   task automatic chk(input string nm, input logic ev, input logic [31:0] ed);
      n_vec++;
      if (vout !== ev || dout !== ed) begin
         n_bad++;
         $display("FAIL %s: got valid=%b data=%h, want valid=%b data=%h", nm, vout, dout, ev, ed);
      end
   endtask
   task automatic tick(input logic r, input logic v, input logic [23:0] d);
      logic [31:0] e;
      rst = r;
      vld = v;
      din = d;
      @(posedge clk);
      if (r) begin
         m_inc  = '0;
         m_acc  = '0;
         m_fill = 0;
         sb.delete();
         sb.push_back(exp_iq('0));
      end else begin
         m_acc = m_acc + m_inc;
         if (v) m_inc = d;
         if (m_fill < 3) m_fill++;
         sb.push_back(exp_iq(m_acc));
      end
      #1;
      if (m_fill == 3) begin
         e = sb.pop_front();
         chk("scoreboard", 1'b1, e);
      end else chk("scoreboard_fill", 1'b0, 32'h0);
   endtask
   task automatic step_seq(input int hold);
      tick(1, 0, 0);
      repeat (3) tick(0, 0, 0);
      for (int h = 0; h < hold; h++) tick(0, 1, 24'h400000);
      for (int k = hold; k <= 5; k++) begin
         tick(0, 0, 0);
         if (k == 2 || k == 3) chk("step_before", 1'b1, 32'h00197FFF);
         if (k == 4) chk("step_first", 1'b1, 32'h7FFFFFE7);
         if (k == 5) chk("step_next", 1'b1, 32'hFFE78001);
      end
   endtask
   initial begin
      longint p, err;
      int qq, ii;
      tbl[0]  = '{1'b1, 1'b0, 24'h0,      1'b1, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'h00197FFF};
      tbl[4]  = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'h00197FFF};
      tbl[5]  = '{1'b0, 1'b1, 24'h400000, 1'b1, 1'b1, 32'h00197FFF};
      tbl[6]  = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'h00197FFF};
      tbl[7]  = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'h00197FFF};
      tbl[8]  = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'h00197FFF};
      tbl[9]  = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'h7FFFFFE7};
      tbl[10] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'hFFE78001};
      tbl[11] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'h80010019};
      tbl[12] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'h00197FFF};
      tbl[13] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'h7FFFFFE7};
      tbl[14] = '{1'b1, 1'b0, 24'h0,      1'b1, 1'b0, 32'h0};
      tbl[15] = '{1'b0, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, 32'h0};
      tbl[16] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 32'h0};
      tbl[17] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'h00197FFF};
      tbl[18] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'h00197FFF};
      tbl[19] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'hFFE77FFF};
      tbl[20] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 32'hFFE77FFF};
      for (int n = 0; n < 21; n++) begin
         tick(tbl[n].r, tbl[n].v, tbl[n].d);
         if (tbl[n].chk) chk($sformatf("vec%0d", n), tbl[n].ev, tbl[n].ed);
      end
      step_seq(1);
      step_seq(2);
      tick(1, 0, 0);
      tick(0, 1, 24'h400000);
      repeat (6) tick(0, 0, 0);
      tick(1, 1, 24'h123456);
      chk("rst_mid_edge", 1'b0, 32'h0);
      repeat (2) begin
         tick(0, 0, 0);
         chk("rst_mid_fill", 1'b0, 32'h0);
      end
      repeat (3) begin
         tick(0, 0, 0);
         chk("rst_mid_after", 1'b1, 32'h00197FFF);
      end
      tick(1, 0, 0);
      tick(0, 1, 24'h000800);
      for (int n = 0; n < 8195; n++) begin
         tick(0, 0, 0);
         if (vout) begin
            qq  = int'($signed(dout[31:16]));
            ii  = int'($signed(dout[15:0]));
            p   = longint'(qq) * qq + longint'(ii) * ii;
            err = p - 64'sd1073676289;
            if (err < 0) err = -err;
            n_vec++;
            if (qq < -32767 || ii < -32767 || err > 64'sd1073676) begin
               n_bad++;
               $display("FAIL sweep_mag: got Q=%0d I=%0d pow=%0d, want |Q|,|I|<=32767 pow within 1073676 of 1073676289", qq, ii, p);
            end
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
